scope_timebase_ctrl: RTL

- Controls the oscilloscope timebase, selecting one of five ms-per-screen settings (10/20/40/80/160 ms).
- Driven by two push buttons: BTN_UP and BTN_DN.
- Generates the sample-enable strobe for the capture datapath.
- Presents the selected setting to the on-screen timebase label renderer. Changes apply only at a frame boundary, so the label and the trace never tear mid-frame.

---
 rtl/scope_timebase_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/scope_timebase_ctrl.sv
// scope_timebase_ctrl: oscilloscope timebase selector driven by two push
// buttons. Requested settings wait for a video frame boundary before they
// take effect, and a sample-enable strobe is divided down from CLK according
// to the active setting.
// Build option: define TB_WRAP_EN to make the pending index wrap around at
// both ends instead of saturating.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | pending index equals active setting, nothing to do
// ST_PENDING | new setting requested, waiting for an unfrozen frame end
// ST_APPLY   | one cycle: commit pending index, restart divider/capture
module scope_timebase_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BASE_DIV        = 781,
    parameter int NUM_SETTINGS    = 5,
    parameter int RESET_SEL       = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_UP,
    input  logic       BTN_DN,
    input  logic       VGA_FRAME_END,
    input  logic       FREEZE,
    output logic [2:0] TB_SEL,
    output logic       TB_PENDING,
    output logic       SAMPLE_EN,
    output logic       CAPTURE_RESTART
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      IDX_MAX = 3'(NUM_SETTINGS - 1);
    localparam logic [2:0]      IDX_RST = 3'(RESET_SEL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      btn_raw;
    logic [1:0]      sync_a, sync_b;
    logic [1:0]      deb, deb_prev;
    logic [DB_W-1:0] db_cnt [2];
    logic            up_step, dn_step;
    logic [2:0]      pend_idx, idx_inc, idx_dec;
    logic [15:0]     div_cnt, div_last;

    // bit 0 = UP, bit 1 = DN throughout the conditioning path
    assign btn_raw = {BTN_DN, BTN_UP};

    // Two-flop synchronizer for the asynchronous button inputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debouncer: down-counter reloads on any agreeing cycle, level flips at terminal count
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= DB_LOAD;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= DB_LOAD;
                end else if (db_cnt[i] == '0) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= DB_LOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Press (not release) produces a single-cycle step
    assign up_step = deb[0] & ~deb_prev[0];
    assign dn_step = deb[1] & ~deb_prev[1];

    // Neighbouring indices with end-of-range handling
    always_comb begin
        idx_inc = pend_idx + 3'd1;
        idx_dec = pend_idx - 3'd1;
        if (pend_idx >= IDX_MAX) begin
`ifdef TB_WRAP_EN
            idx_inc = '0;
`else
            idx_inc = IDX_MAX;
`endif
        end
        if (pend_idx == '0) begin
`ifdef TB_WRAP_EN
            idx_dec = IDX_MAX;
`else
            idx_dec = '0;
`endif
        end
    end

    // Pending index follows the steps; simultaneous UP and DN cancel out
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_idx <= IDX_RST;
        end else if (up_step && !dn_step) begin
            pend_idx <= idx_inc;
        end else if (dn_step && !up_step) begin
            pend_idx <= idx_dec;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state; a frozen capture keeps the request parked in PENDING
    always_comb begin
        state_nxt  = state;
        TB_PENDING = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_idx != TB_SEL) state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                TB_PENDING = 1'b1;
                if (pend_idx == TB_SEL)              state_nxt = ST_IDLE;
                else if (VGA_FRAME_END && !FREEZE)   state_nxt = ST_APPLY;
            end
            ST_APPLY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Commit the new setting and flag the capture buffer one cycle later
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TB_SEL          <= IDX_RST;
            CAPTURE_RESTART <= 1'b0;
        end else begin
            CAPTURE_RESTART <= (state == ST_APPLY);
            if (state == ST_APPLY) TB_SEL <= pend_idx;
        end
    end

    assign div_last = (16'(BASE_DIV) << TB_SEL) - 16'd1;

    // Sample divider: restarts on apply, holds while frozen
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (state == ST_APPLY) begin
            div_cnt <= '0;
        end else if (!FREEZE) begin
            div_cnt <= (div_cnt == div_last) ? 16'd0 : div_cnt + 16'd1;
        end
    end

    assign SAMPLE_EN = !FREEZE && (div_cnt == div_last);

endmodule
